// File: rtl/spectrum_peak_analyzer.sv
// spectrum_peak_analyzer
//   Scans the FFT magnitude RAM from bin BIN_LO-1 to BIN_HI+1. The two outer
//   bins are guard samples that are never reported as peaks. A bin is a peak
//   when it is a local maximum above a runtime threshold. The NUM_PEAKS
//   largest peaks are kept in a table sorted by magnitude, and the spectrum is
//   classified as CW, AM or FM from the total peak count.
//
//   Optional feature macro: SPA_ENERGY_EN
//     defined   -> energy = sum of rd_data over bins BIN_LO..BIN_HI
//     undefined -> energy tied to 0, no accumulator
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        single-cycle scan request (honoured only while idle)
//   thresh       minimum peak magnitude (strictly exceeded)
//   rd_addr      RAM read address; holds its last value while idle
//   rd_data      RAM read data, one-cycle latency
//   busy         scan in progress
//   done         one-cycle pulse; results valid and stable until next start
//   peak_bin     NUM_PEAKS bins, slot 0 (largest) in the LSBs
//   peak_mag     matching magnitudes
//   peak_cnt     total peaks detected, saturating
//   spacing      |bin(slot1) - bin(slot0)|, 0 with fewer than two peaks
//   mod_type     000 none, 001 CW, 010 AM, 100 FM
//   energy       sum of scanned magnitudes (see macro above)
module spectrum_peak_analyzer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int NUM_PEAKS = 4,
  parameter int BIN_LO    = 1,
  parameter int BIN_HI    = 127
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DATA_W-1:0]             thresh,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_PEAKS*ADDR_W-1:0]   peak_bin,
  output logic [NUM_PEAKS*DATA_W-1:0]   peak_mag,
  output logic [ADDR_W-1:0]             peak_cnt,
  output logic [ADDR_W-1:0]             spacing,
  output logic [2:0]                    mod_type,
  output logic [DATA_W+ADDR_W-1:0]      energy
);

  localparam int E_W = DATA_W + ADDR_W;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BIN_LO - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BIN_HI + 1);
  // The first full window has bin BIN_LO as its centre, so its "next"
  // sample comes from bin BIN_LO+1.
  localparam logic [ADDR_W-1:0] WIN_FIRST  = ADDR_W'(BIN_LO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_CLASSIFY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Scan pipeline
  logic [ADDR_W-1:0] rd_addr_q;
  logic              data_vld_q;   // rd_data holds a scanned sample this cycle
  logic [ADDR_W-1:0] data_bin_q;   // bin that rd_data belongs to
  logic [DATA_W-1:0] prev_q, cur_q;

  // Registered peak candidate, inserted one cycle after detection
  logic              cand_vld_q;
  logic [ADDR_W-1:0] cand_bin_q;
  logic [DATA_W-1:0] cand_mag_q;

  // Sorted peak table, slot 0 = largest
  logic [ADDR_W-1:0]    pk_bin_q [NUM_PEAKS];
  logic [DATA_W-1:0]    pk_mag_q [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] pk_vld_q;

  logic [ADDR_W-1:0]    ins_bin [NUM_PEAKS];
  logic [DATA_W-1:0]    ins_mag [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] ins_vld;
  logic [NUM_PEAKS-1:0] beats;

  logic [ADDR_W-1:0] peak_cnt_q;
  logic [ADDR_W-1:0] spacing_q;
  logic [ADDR_W-1:0] spacing_d;
  logic [2:0]        mod_type_q;
  logic [2:0]        mod_type_d;
  logic              done_q;

  logic              win_peak;
  logic [ADDR_W-1:0] cur_bin;
  logic              accept;

  // ---------------------------------------------------------------- FSM
  // NOTE: state is written with <= so every register updates from the same
  // pre-edge values; a blocking = here would create simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_READ;
      S_READ:     if (rd_addr_q == LAST_ADDR) state_d = S_FLUSH;
      S_FLUSH:    state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && start;

  // -------------------------------------------------------- peak detection
  // cur is a peak when it beats thresh and prev strictly, and is not beaten
  // by next. The strict/non-strict pair reports only the first bin of a flat
  // top.
  assign cur_bin  = data_bin_q - ADDR_W'(1);
  assign win_peak = data_vld_q && (data_bin_q >= WIN_FIRST) &&
                    (cur_q > thresh) && (cur_q > prev_q) && (cur_q >= rd_data);

  // ------------------------------------------------------- sorted insertion
  // beats[i]: the candidate belongs at or above slot i. Because the table is
  // sorted and empty slots sit at the bottom, beats is a thermometer code;
  // the lowest-index set bit is the insertion slot. A strict compare keeps an
  // earlier equal-magnitude peak in the higher slot.
  always_comb begin
    for (int i = 0; i < NUM_PEAKS; i++) begin
      beats[i]   = !pk_vld_q[i] || (cand_mag_q > pk_mag_q[i]);
      ins_bin[i] = pk_bin_q[i];
      ins_mag[i] = pk_mag_q[i];
      ins_vld[i] = pk_vld_q[i];
    end
    if (beats[0]) begin
      ins_bin[0] = cand_bin_q;
      ins_mag[0] = cand_mag_q;
      ins_vld[0] = 1'b1;
    end
    for (int i = 1; i < NUM_PEAKS; i++) begin
      if (beats[i] && beats[i-1]) begin
        ins_bin[i] = pk_bin_q[i-1];
        ins_mag[i] = pk_mag_q[i-1];
        ins_vld[i] = pk_vld_q[i-1];
      end else if (beats[i]) begin
        ins_bin[i] = cand_bin_q;
        ins_mag[i] = cand_mag_q;
        ins_vld[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- classification
  always_comb begin
    mod_type_d = 3'b000;
    if (peak_cnt_q == ADDR_W'(1))      mod_type_d = 3'b001;
    else if (peak_cnt_q == ADDR_W'(2) ||
             peak_cnt_q == ADDR_W'(3)) mod_type_d = 3'b010;
    else if (peak_cnt_q != '0)         mod_type_d = 3'b100;
  end

  generate
    if (NUM_PEAKS >= 2) begin : g_spacing
      always_comb begin
        spacing_d = '0;
        if (pk_vld_q[1])
          spacing_d = (pk_bin_q[1] > pk_bin_q[0]) ? pk_bin_q[1] - pk_bin_q[0]
                                                  : pk_bin_q[0] - pk_bin_q[1];
      end
    end else begin : g_no_spacing
      assign spacing_d = '0;
    end
  endgenerate

  // --------------------------------------------------------------- datapath
  // NOTE: the peak table is a handful of flops, not a RAM, so it is reset
  // like any other state; the unused-slot-reads-zero rule relies on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      data_vld_q <= 1'b0;
      data_bin_q <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      cand_vld_q <= 1'b0;
      cand_bin_q <= '0;
      cand_mag_q <= '0;
      pk_vld_q   <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        pk_bin_q[i] <= '0;
        pk_mag_q[i] <= '0;
      end
      peak_cnt_q <= '0;
      spacing_q  <= '0;
      mod_type_q <= '0;
      done_q     <= 1'b0;
    end else begin
      data_vld_q <= (state_q == S_READ);
      data_bin_q <= rd_addr_q;
      done_q     <= (state_q == S_DONE);
      if (data_vld_q) begin
        prev_q <= cur_q;
        cur_q  <= rd_data;
      end
      cand_bin_q <= cur_bin;
      cand_mag_q <= cur_q;

      if (accept) begin
        rd_addr_q  <= FIRST_ADDR;
        cand_vld_q <= 1'b0;
        pk_vld_q   <= '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
          pk_bin_q[i] <= '0;
          pk_mag_q[i] <= '0;
        end
        peak_cnt_q <= '0;
        spacing_q  <= '0;
        mod_type_q <= '0;
      end else begin
        cand_vld_q <= win_peak;
        if (state_q == S_READ && rd_addr_q != LAST_ADDR)
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (cand_vld_q) begin
          pk_vld_q <= ins_vld;
          for (int i = 0; i < NUM_PEAKS; i++) begin
            pk_bin_q[i] <= ins_bin[i];
            pk_mag_q[i] <= ins_mag[i];
          end
          if (peak_cnt_q != '1) peak_cnt_q <= peak_cnt_q + ADDR_W'(1);
        end
        if (state_q == S_DONE) begin
          mod_type_q <= mod_type_d;
          spacing_q  <= spacing_d;
        end
      end
    end
  end

  // ------------------------------------------------------------------ energy
`ifdef SPA_ENERGY_EN
  logic [E_W-1:0] energy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_q <= '0;
    end else if (accept) begin
      energy_q <= '0;
    end else if (data_vld_q && data_bin_q >= ADDR_W'(BIN_LO) &&
                 data_bin_q <= ADDR_W'(BIN_HI)) begin
      energy_q <= energy_q + E_W'(rd_data);
    end
  end

  assign energy = energy_q;
`else
  assign energy = '0;
`endif

  // ----------------------------------------------------------------- outputs
  always_comb begin
    for (int i = 0; i < NUM_PEAKS; i++) begin
      peak_bin[i*ADDR_W +: ADDR_W] = pk_bin_q[i];
      peak_mag[i*DATA_W +: DATA_W] = pk_mag_q[i];
    end
  end

  assign rd_addr  = rd_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign peak_cnt = peak_cnt_q;
  assign spacing  = spacing_q;
  assign mod_type = mod_type_q;

endmodule

// File: tb/tb_spectrum_peak_analyzer.sv
// Testbench for spectrum_peak_analyzer with default parameters. A behavioural
// 256x16 RAM with one-cycle read latency feeds the DUT. Each scenario task
// loads the RAM, runs one scan and compares timing and results with
// hand-computed values.
module tb_spectrum_peak_analyzer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NP = 4;
  localparam int DONE_CYC = 133;

`ifdef SPA_ENERGY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   thresh = '0;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data = '0;
  logic            busy, done;
  logic [NP*AW-1:0] peak_bin;
  logic [NP*DW-1:0] peak_mag;
  logic [AW-1:0]   peak_cnt, spacing;
  logic [2:0]      mod_type;
  logic [DW+AW-1:0] energy;

  logic [DW-1:0]   mem [256];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  spectrum_peak_analyzer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .thresh   (thresh),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .peak_bin (peak_bin),
    .peak_mag (peak_mag),
    .peak_cnt (peak_cnt),
    .spacing  (spacing),
    .mod_type (mod_type),
    .energy   (energy)
  );

  task automatic fill_mem(input logic [DW-1:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Starts a scan (start high in cycle 0) and watches cycles 1..145.
  // An optional second start pulse is driven in cycle extra_start.
  task automatic scan(input int extra_start, output int done_cyc,
                      output int n_done, output int busy_bad);
    done_cyc = -1;
    n_done   = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 145; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (c >= 1 && c <= DONE_CYC - 1)) busy_bad++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, rd_addr, peak_cnt, spacing, mod_type} !== '0)
      $display("FAIL reset_ctrl got %h want 0", {busy, done, rd_addr, peak_cnt, spacing, mod_type}); else passed++;
    total++; if ({peak_bin, peak_mag, energy} !== '0)
      $display("FAIL reset_table got %h want 0", {peak_bin, peak_mag, energy}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_peaks;
    int dc, nd, bb;
    fill_mem('0);
    thresh = 16'd10;
    scan(0, dc, nd, bb);
    total++; if (dc !== DONE_CYC) $display("FAIL s1_done_cycle got %0d want %0d", dc, DONE_CYC); else passed++;
    total++; if (nd !== 1) $display("FAIL s1_done_count got %0d want 1", nd); else passed++;
    total++; if (bb !== 0) $display("FAIL s1_busy_window got %0d bad cycles want 0", bb); else passed++;
    total++; if ({peak_cnt, mod_type, spacing} !== '0)
      $display("FAIL s1_results got %h want 0", {peak_cnt, mod_type, spacing}); else passed++;
    total++; if ({peak_bin, peak_mag} !== '0) $display("FAIL s1_table got %h want 0", {peak_bin, peak_mag}); else passed++;
  endtask

  task automatic test_single_peak;
    int dc, nd, bb;
    fill_mem(16'd5);
    mem[40] = 16'd1000;
    thresh  = 16'd10;
    scan(0, dc, nd, bb);
    total++; if (dc !== DONE_CYC) $display("FAIL s2_done_cycle got %0d want %0d", dc, DONE_CYC); else passed++;
    total++; if (peak_cnt !== 8'd1) $display("FAIL s2_cnt got %0d want 1", peak_cnt); else passed++;
    total++; if (peak_bin !== 32'd40) $display("FAIL s2_bins got %h want %h", peak_bin, 32'd40); else passed++;
    total++; if (peak_mag !== 64'd1000) $display("FAIL s2_mags got %h want %h", peak_mag, 64'd1000); else passed++;
    total++; if (mod_type !== 3'b001) $display("FAIL s2_mod got %b want 001", mod_type); else passed++;
    total++; if (spacing !== 8'd0) $display("FAIL s2_spacing got %0d want 0", spacing); else passed++;
    total++; if (energy !== (EN ? 24'd1630 : 24'd0))
      $display("FAIL s2_energy got %0d want %0d", energy, EN ? 1630 : 0); else passed++;
  endtask

  task automatic test_three_peaks;
    int dc, nd, bb;
    fill_mem('0);
    mem[40] = 16'd1000;
    mem[35] = 16'd300;
    mem[45] = 16'd300;
    thresh  = 16'd10;
    scan(0, dc, nd, bb);
    total++; if (peak_cnt !== 8'd3) $display("FAIL s3_cnt got %0d want 3", peak_cnt); else passed++;
    total++; if (peak_bin !== {8'd0, 8'd45, 8'd35, 8'd40})
      $display("FAIL s3_bins got %h want %h", peak_bin, {8'd0, 8'd45, 8'd35, 8'd40}); else passed++;
    total++; if (peak_mag !== {16'd0, 16'd300, 16'd300, 16'd1000})
      $display("FAIL s3_mags got %h want %h", peak_mag, {16'd0, 16'd300, 16'd300, 16'd1000}); else passed++;
    total++; if (spacing !== 8'd5) $display("FAIL s3_spacing got %0d want 5", spacing); else passed++;
    total++; if (mod_type !== 3'b010) $display("FAIL s3_mod got %b want 010", mod_type); else passed++;
  endtask

  task automatic load_six_peaks;
    fill_mem('0);
    for (int k = 0; k < 6; k++) mem[20 + 10*k] = DW'(100 * (k + 1));
    thresh = 16'd10;
  endtask

  task automatic test_many_peaks;
    int dc, nd, bb;
    load_six_peaks();
    scan(0, dc, nd, bb);
    total++; if (dc !== DONE_CYC) $display("FAIL s4_done_cycle got %0d want %0d", dc, DONE_CYC); else passed++;
    total++; if (peak_cnt !== 8'd6) $display("FAIL s4_cnt got %0d want 6", peak_cnt); else passed++;
    total++; if (peak_bin !== {8'd40, 8'd50, 8'd60, 8'd70})
      $display("FAIL s4_bins got %h want %h", peak_bin, {8'd40, 8'd50, 8'd60, 8'd70}); else passed++;
    total++; if (peak_mag !== {16'd300, 16'd400, 16'd500, 16'd600})
      $display("FAIL s4_mags got %h want %h", peak_mag, {16'd300, 16'd400, 16'd500, 16'd600}); else passed++;
    total++; if (spacing !== 8'd10) $display("FAIL s4_spacing got %0d want 10", spacing); else passed++;
    total++; if (mod_type !== 3'b100) $display("FAIL s4_mod got %b want 100", mod_type); else passed++;
    total++; if (energy !== (EN ? 24'd2100 : 24'd0))
      $display("FAIL s4_energy got %0d want %0d", energy, EN ? 2100 : 0); else passed++;
  endtask

  // Peaks in the first and last scanned bins, a guard bin that must not be
  // counted, and a bin exactly at the threshold that must not qualify.
  task automatic test_edges_thresh;
    int dc, nd, bb;
    fill_mem('0);
    mem[1]   = 16'd500;
    mem[64]  = 16'd300;
    mem[127] = 16'd700;
    mem[128] = 16'd100;
    thresh   = 16'd300;
    scan(0, dc, nd, bb);
    total++; if (peak_cnt !== 8'd2) $display("FAIL edge_cnt got %0d want 2", peak_cnt); else passed++;
    total++; if (peak_bin !== {8'd0, 8'd0, 8'd1, 8'd127})
      $display("FAIL edge_bins got %h want %h", peak_bin, {8'd0, 8'd0, 8'd1, 8'd127}); else passed++;
    total++; if (peak_mag !== {16'd0, 16'd0, 16'd500, 16'd700})
      $display("FAIL edge_mags got %h want %h", peak_mag, {16'd0, 16'd0, 16'd500, 16'd700}); else passed++;
    total++; if (spacing !== 8'd126) $display("FAIL edge_spacing got %0d want 126", spacing); else passed++;
    total++; if (energy !== (EN ? 24'd1500 : 24'd0))
      $display("FAIL edge_energy got %0d want %0d", energy, EN ? 1500 : 0); else passed++;
  endtask

  task automatic test_plateau_restart;
    int dc, nd, bb;
    fill_mem('0);
    mem[50] = 16'd800;
    mem[51] = 16'd800;
    thresh  = 16'd10;
    scan(60, dc, nd, bb);
    total++; if (dc !== DONE_CYC) $display("FAIL s5_done_cycle got %0d want %0d", dc, DONE_CYC); else passed++;
    total++; if (nd !== 1) $display("FAIL s5_done_count got %0d want 1", nd); else passed++;
    total++; if (bb !== 0) $display("FAIL s5_busy_window got %0d bad cycles want 0", bb); else passed++;
    total++; if (peak_cnt !== 8'd1) $display("FAIL s5_cnt got %0d want 1", peak_cnt); else passed++;
    total++; if (peak_bin !== 32'd50) $display("FAIL s5_bins got %h want %h", peak_bin, 32'd50); else passed++;
    total++; if (mod_type !== 3'b001) $display("FAIL s5_mod got %b want 001", mod_type); else passed++;
  endtask

  task automatic test_abort_reset;
    int dc, nd, bb;
    int stray;
    stray = 0;
    load_six_peaks();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, rd_addr, peak_cnt, spacing, mod_type} !== '0)
      $display("FAIL abort_ctrl got %h want 0", {busy, done, rd_addr, peak_cnt, spacing, mod_type}); else passed++;
    total++; if ({peak_bin, peak_mag, energy} !== '0)
      $display("FAIL abort_table got %h want 0", {peak_bin, peak_mag, energy}); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) stray++;
    end
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    total++; if (stray !== 0) $display("FAIL abort_stray got %0d done/busy cycles want 0", stray); else passed++;
    scan(0, dc, nd, bb);
    total++; if (dc !== DONE_CYC) $display("FAIL s6_done_cycle got %0d want %0d", dc, DONE_CYC); else passed++;
    total++; if (nd !== 1) $display("FAIL s6_done_count got %0d want 1", nd); else passed++;
    total++; if (peak_bin !== {8'd40, 8'd50, 8'd60, 8'd70})
      $display("FAIL s6_bins got %h want %h", peak_bin, {8'd40, 8'd50, 8'd60, 8'd70}); else passed++;
    total++; if (mod_type !== 3'b100) $display("FAIL s6_mod got %b want 100", mod_type); else passed++;
  endtask

  initial begin
    fill_mem('0);
    test_reset();
    test_no_peaks();
    test_single_peak();
    test_three_peaks();
    test_many_peaks();
    test_edges_thresh();
    test_plateau_restart();
    test_abort_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
